// File: rtl/alu_issue.sv
// Issue stage in front of the 16-bit ALU.
// Accepts one decoded instruction at a time, reads operands from the 8x16
// register file, drives the ALU for one cycle, writes the result back and
// resolves branches from the latched flag snapshot into a PC-load pulse.

`ifndef OP_MOV
`define OP_MOV  4'h0
`endif
`ifndef OP_ADD
`define OP_ADD  4'h1
`endif
`ifndef OP_ADC
`define OP_ADC  4'h2
`endif
`ifndef OP_SUB
`define OP_SUB  4'h3
`endif
`ifndef OP_SBC
`define OP_SBC  4'h4
`endif
`ifndef OP_CMP
`define OP_CMP  4'h5
`endif
`ifndef OP_AND
`define OP_AND  4'h6
`endif
`ifndef OP_OR
`define OP_OR   4'h7
`endif
`ifndef OP_XOR
`define OP_XOR  4'h8
`endif
`ifndef OP_NOT
`define OP_NOT  4'h9
`endif
`ifndef OP_NEG
`define OP_NEG  4'hA
`endif
`ifndef OP_INC
`define OP_INC  4'hB
`endif
`ifndef OP_DEC
`define OP_DEC  4'hC
`endif
`ifndef OP_RLC
`define OP_RLC  4'hD
`endif
`ifndef OP_RRC
`define OP_RRC  4'hE
`endif
`ifndef OP_BREQ
`define OP_BREQ 4'h0
`endif
`ifndef OP_BRNE
`define OP_BRNE 4'h1
`endif
`ifndef OP_BRLT
`define OP_BRLT 4'h2
`endif
`ifndef OP_BRGE
`define OP_BRGE 4'h3
`endif
`ifndef OP_BRC
`define OP_BRC  4'h4
`endif
`ifndef OP_BRLO
`define OP_BRLO 4'h4
`endif
`ifndef OP_BRNC
`define OP_BRNC 4'h5
`endif
`ifndef OP_BRSH
`define OP_BRSH 4'h5
`endif
`ifndef OP_BRO
`define OP_BRO  4'h6
`endif
`ifndef OP_BRNO
`define OP_BRNO 4'h7
`endif
`ifndef OP_BRN
`define OP_BRN  4'h8
`endif
`ifndef OP_BRNN
`define OP_BRNN 4'h9
`endif
`ifndef OP_RJMP
`define OP_RJMP 4'hA
`endif

module alu_issue #(
    parameter int REGS  = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_kind,
    input  logic [3:0]               in_op,
    input  logic [$clog2(REGS)-1:0]  in_dst,
    input  logic [$clog2(REGS)-1:0]  in_src,
    input  logic                     in_imm_en,
    input  logic [WIDTH-1:0]         in_imm,
    output logic [WIDTH-1:0]         alu_value1,
    output logic [WIDTH-1:0]         alu_value2,
    output logic [3:0]               alu_operator,
    output logic                     alu_single,
    input  logic [WIDTH-1:0]         alu_bus_out,
    input  logic [4:0]               alu_flags,
    output logic [4:0]               flags_out,
    output logic                     pc_load,
    output logic [WIDTH-1:0]         pc_target,
    input  logic [$clog2(REGS)-1:0]  dbg_addr,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int IDX_W = $clog2(REGS);

    localparam logic [1:0] KIND_ALU2 = 2'd0;
    localparam logic [1:0] KIND_ALU1 = 2'd1;
    localparam logic [1:0] KIND_BR   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_BR   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [REGS];
    logic [WIDTH-1:0]   regs_d [REGS];
    logic [4:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   value1_q, value1_d;
    logic [WIDTH-1:0]   value2_q, value2_d;
    logic [3:0]         operator_q, operator_d;
    logic               single_q, single_d;
    logic [IDX_W-1:0]   dst_q, dst_d;
    logic               nowb_q, nowb_d;
    logic [3:0]         cond_q, cond_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic               pc_load_q, pc_load_d;
    logic [WIDTH-1:0]   pc_target_q, pc_target_d;

    // Flags are {old_sign, C, V, Z, N}; BRLO/BRSH share the BRC/BRNC codes.
    function automatic logic br_taken(input logic [3:0] cond, input logic [4:0] f);
        logic c, v, z, n;
        c = f[3];
        v = f[2];
        z = f[1];
        n = f[0];
        case (cond)
            `OP_BREQ: br_taken = z;
            `OP_BRNE: br_taken = !z;
            `OP_BRLT: br_taken = n ^ v;
            `OP_BRGE: br_taken = !(n ^ v);
            `OP_BRC:  br_taken = c;
            `OP_BRNC: br_taken = !c;
            `OP_BRO:  br_taken = v;
            `OP_BRNO: br_taken = !v;
            `OP_BRN:  br_taken = n;
            `OP_BRNN: br_taken = !n;
            `OP_RJMP: br_taken = 1'b1;
            default:  br_taken = 1'b0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ALU ops take EXEC+WB, branches take one BR cycle, NOPs stay idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (in_kind)
                        KIND_ALU2, KIND_ALU1: state_d = S_EXEC;
                        KIND_BR:              state_d = S_BR;
                        default:              state_d = S_IDLE;
                    endcase
                end
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_BR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake is open only while idle
    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    // Datapath next values; ALU inputs default to the park pattern (MOV 0, keeps carry)
    always_comb begin
        regs_d      = regs_q;
        flags_d     = flags_q;
        value1_d    = '0;
        value2_d    = '0;
        operator_d  = `OP_MOV;
        single_d    = 1'b0;
        dst_d       = dst_q;
        nowb_d      = nowb_q;
        cond_d      = cond_q;
        target_d    = target_q;
        pc_load_d   = 1'b0;
        pc_target_d = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (in_kind)
                        KIND_ALU2: begin
                            value1_d   = regs_q[in_dst];
                            value2_d   = in_imm_en ? in_imm : regs_q[in_src];
                            operator_d = in_op;
                            single_d   = 1'b0;
                            dst_d      = in_dst;
                            nowb_d     = (in_op == `OP_CMP);
                        end
                        KIND_ALU1: begin
                            value1_d   = regs_q[in_dst];
                            value2_d   = '0;
                            operator_d = in_op;
                            single_d   = 1'b1;
                            dst_d      = in_dst;
                            nowb_d     = 1'b0;
                        end
                        KIND_BR: begin
                            cond_d   = in_op;
                            target_d = in_imm_en ? in_imm : regs_q[in_src];
                        end
                        default: ;
                    endcase
                end
            end
            S_WB: begin
                // ALU registered this instruction's result at the end of EXEC
                if (!nowb_q) begin
                    regs_d[dst_q] = alu_bus_out;
                end
                flags_d = alu_flags;
            end
            S_BR: begin
                pc_load_d   = br_taken(cond_q, flags_q);
                pc_target_d = pc_load_d ? target_q : '0;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q     <= '0;
            value1_q    <= '0;
            value2_q    <= '0;
            operator_q  <= `OP_MOV;
            single_q    <= 1'b0;
            dst_q       <= '0;
            nowb_q      <= 1'b0;
            cond_q      <= '0;
            target_q    <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
        end else begin
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            value1_q    <= value1_d;
            value2_q    <= value2_d;
            operator_q  <= operator_d;
            single_q    <= single_d;
            dst_q       <= dst_d;
            nowb_q      <= nowb_d;
            cond_q      <= cond_d;
            target_q    <= target_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign alu_value1   = value1_q;
    assign alu_value2   = value2_q;
    assign alu_operator = operator_q;
    assign alu_single   = single_q;
    assign flags_out    = flags_q;
    assign pc_load      = pc_load_q;
    assign pc_target    = pc_target_q;
    assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: emulates the ALU, keeps a transaction-level model of
// the register file, flags and branch pulses, and compares every cycle.

`ifndef OP_MOV
`define OP_MOV  4'h0
`endif
`ifndef OP_ADD
`define OP_ADD  4'h1
`endif
`ifndef OP_ADC
`define OP_ADC  4'h2
`endif
`ifndef OP_SUB
`define OP_SUB  4'h3
`endif
`ifndef OP_SBC
`define OP_SBC  4'h4
`endif
`ifndef OP_CMP
`define OP_CMP  4'h5
`endif
`ifndef OP_AND
`define OP_AND  4'h6
`endif
`ifndef OP_OR
`define OP_OR   4'h7
`endif
`ifndef OP_XOR
`define OP_XOR  4'h8
`endif
`ifndef OP_NOT
`define OP_NOT  4'h9
`endif
`ifndef OP_NEG
`define OP_NEG  4'hA
`endif
`ifndef OP_INC
`define OP_INC  4'hB
`endif
`ifndef OP_DEC
`define OP_DEC  4'hC
`endif
`ifndef OP_RLC
`define OP_RLC  4'hD
`endif
`ifndef OP_RRC
`define OP_RRC  4'hE
`endif
`ifndef OP_BREQ
`define OP_BREQ 4'h0
`endif
`ifndef OP_BRNE
`define OP_BRNE 4'h1
`endif
`ifndef OP_BRLT
`define OP_BRLT 4'h2
`endif
`ifndef OP_BRGE
`define OP_BRGE 4'h3
`endif
`ifndef OP_BRC
`define OP_BRC  4'h4
`endif
`ifndef OP_BRNC
`define OP_BRNC 4'h5
`endif
`ifndef OP_BRO
`define OP_BRO  4'h6
`endif
`ifndef OP_BRNO
`define OP_BRNO 4'h7
`endif
`ifndef OP_BRN
`define OP_BRN  4'h8
`endif
`ifndef OP_BRNN
`define OP_BRNN 4'h9
`endif
`ifndef OP_RJMP
`define OP_RJMP 4'hA
`endif

module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'd3;
    logic [3:0]  in_op = 4'h0;
    logic [2:0]  in_dst = 3'd0;
    logic [2:0]  in_src = 3'd0;
    logic        in_imm_en = 1'b0;
    logic [15:0] in_imm = 16'h0;
    logic [15:0] alu_value1, alu_value2;
    logic [3:0]  alu_operator;
    logic        alu_single;
    logic [15:0] alu_bus_out = 16'h0;
    logic [4:0]  alu_flags = 5'h0;
    logic [4:0]  flags_out;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_op(in_op),
        .in_dst(in_dst), .in_src(in_src), .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_operator(alu_operator),
        .alu_single(alu_single), .alu_bus_out(alu_bus_out), .alu_flags(alu_flags),
        .flags_out(flags_out), .pc_load(pc_load), .pc_target(pc_target),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic [4:0]  f;
        logic        c;
    } alu_t;

    // Behavioural ALU: result, flags {old_sign,C,V,Z,N} and carry-out
    function automatic alu_t alu_fn(input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] op, input logic cin);
        alu_t        x;
        logic [16:0] w;
        logic [15:0] r;
        logic        c, v;
        c = cin; v = 1'b0; r = a; w = 17'h0;
        case (op)
            `OP_MOV: r = b;
            `OP_ADD, `OP_ADC: begin
                w = {1'b0, a} + {1'b0, b} + ((op == `OP_ADC) ? {16'h0, cin} : 17'h0);
                r = w[15:0]; c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            `OP_SUB, `OP_CMP, `OP_SBC: begin
                w = {1'b0, a} - {1'b0, b} - ((op == `OP_SBC) ? {16'h0, cin} : 17'h0);
                r = w[15:0]; c = w[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            `OP_AND: r = a & b;
            `OP_OR:  r = a | b;
            `OP_XOR: r = a ^ b;
            `OP_NOT: r = ~a;
            `OP_NEG: begin r = 16'h0 - a; c = (a != 16'h0); v = (a == 16'h8000); end
            `OP_INC: begin r = a + 16'h1; v = (a == 16'h7FFF); end
            `OP_DEC: begin r = a - 16'h1; v = (a == 16'h8000); end
            `OP_RLC: begin r = {a[14:0], cin}; c = a[15]; end
            `OP_RRC: begin r = {cin, a[15:1]}; c = a[0]; end
            default: r = a;
        endcase
        x.r = r;
        x.f = {a[15], c, v, (r == 16'h0), r[15]};
        x.c = c;
        return x;
    endfunction

    function automatic logic cond_holds(input logic [3:0] op, input logic [4:0] f);
        logic c, v, z, n;
        {c, v, z, n} = f[3:0];
        case (op)
            `OP_BREQ: return z;
            `OP_BRNE: return !z;
            `OP_BRLT: return n != v;
            `OP_BRGE: return n == v;
            `OP_BRC:  return c;
            `OP_BRNC: return !c;
            `OP_BRO:  return v;
            `OP_BRNO: return !v;
            `OP_BRN:  return n;
            `OP_BRNN: return !n;
            `OP_RJMP: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    // External ALU: registers its result on every rising edge, carry persists
    logic env_c = 1'b0;
    always @(posedge clk) begin : env_alu
        alu_t x;
        x = alu_fn(alu_value1, alu_value2, alu_operator, env_c);
        alu_bus_out <= x.r;
        alu_flags   <= x.f;
        env_c       <= x.c;
    end

    // Reference model state
    logic [15:0] rm [8];
    logic [4:0]  fm = 5'h0;
    logic        cm = 1'b0;
    int          cyc = 0;
    int          free_at = 0;
    bit          drv_accept = 1'b0;
    bit          pend_valid = 1'b0;
    int          pend_exec_at, pend_wb_at;
    logic [15:0] pv1, pv2, pres;
    logic [3:0]  pop;
    logic        psingle, pwrite, pc;
    logic [4:0]  pfl;
    logic [2:0]  pdst;
    bit          br_valid = 1'b0;
    int          br_at;
    logic        br_tk;
    logic [15:0] br_tgt;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rm[i] = 16'h0;
        fm = 5'h0;
        pend_valid = 1'b0;
        br_valid = 1'b0;
        free_at = cyc;
        drv_accept = 1'b0;
    endtask

    task automatic model_edge();
        alu_t x;
        logic [15:0] a, b;
        if (!rst_n) return;
        if (pend_valid && cyc == pend_exec_at) cm = pc;
        if (pend_valid && cyc == pend_wb_at) begin
            if (pwrite) rm[pdst] = pres;
            fm = pfl;
            pend_valid = 1'b0;
        end
        if (br_valid && cyc > br_at) br_valid = 1'b0;
        if (drv_accept) begin
            case (in_kind)
                2'd0, 2'd1: begin
                    a = rm[in_dst];
                    b = (in_kind == 2'd1) ? 16'h0 : (in_imm_en ? in_imm : rm[in_src]);
                    x = alu_fn(a, b, in_op, cm);
                    pend_valid = 1'b1;
                    pend_exec_at = cyc + 1;
                    pend_wb_at = cyc + 2;
                    pv1 = a; pv2 = b; pop = in_op; psingle = (in_kind == 2'd1);
                    pwrite = !(in_kind == 2'd0 && in_op == `OP_CMP);
                    pdst = in_dst; pres = x.r; pfl = x.f; pc = x.c;
                    free_at = cyc + 2;
                end
                2'd2: begin
                    br_valid = 1'b1;
                    br_at = cyc + 1;
                    br_tk = cond_holds(in_op, fm);
                    br_tgt = in_imm_en ? in_imm : rm[in_src];
                    free_at = cyc + 1;
                end
                default: free_at = cyc;
            endcase
        end
        drv_accept = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model
    task automatic compare();
        bit ex, pl;
        ex = pend_valid && (cyc == pend_exec_at - 1);
        pl = br_valid && (cyc == br_at) && br_tk;
        chk("in_ready", 16'(in_ready), 16'(cyc >= free_at));
        chk("alu_value1", alu_value1, ex ? pv1 : 16'h0);
        chk("alu_value2", alu_value2, ex ? pv2 : 16'h0);
        chk("alu_operator", 16'(alu_operator), 16'(ex ? pop : `OP_MOV));
        chk("alu_single", 16'(alu_single), 16'(ex ? psingle : 1'b0));
        chk("pc_load", 16'(pc_load), 16'(pl));
        chk("pc_target", pc_target, pl ? br_tgt : 16'h0);
        chk("flags_out", 16'(flags_out), 16'(fm));
        chk("dbg_data", dbg_data, rm[dbg_addr]);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one instruction until accepted; returns at the negedge after the accept edge
    task automatic issue(input logic [1:0] k, input logic [3:0] op, input logic [2:0] d,
                         input logic [2:0] s, input logic ie, input logic [15:0] imm);
        bit done;
        done = 1'b0;
        in_kind = k; in_op = op; in_dst = d; in_src = s; in_imm_en = ie; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            drv_accept = (cyc >= free_at) && rst_n;
            done = drv_accept;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("FAIL issue_timeout: instruction never accepted (cycle %0d)", cyc);
        end
    endtask

    task automatic peek(input string name, input logic [2:0] addr, input logic [15:0] exp);
        dbg_addr = addr;
        #1;
        chk(name, dbg_data, exp);
    endtask

    function automatic logic [15:0] pick_imm();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        // 1: reset state
        model_reset();
        in_valid = 1'b1; in_kind = 2'd0; in_op = `OP_MOV; in_imm_en = 1'b1; in_imm = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            tick();
            chk("reset_dbg", dbg_data, 16'h0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("reset_in_ready", 16'(in_ready), 16'h1);
        chk("reset_flags", 16'(flags_out), 16'h0);
        chk("reset_operator", 16'(alu_operator), 16'(`OP_MOV));
        chk("reset_pc_load", 16'(pc_load), 16'h0);

        // 2: MOV immediate, busy exactly two cycles
        issue(2'd0, `OP_MOV, 3'd1, 3'd0, 1'b1, 16'h1234);
        chk("mov_exec_value2", alu_value2, 16'h1234);
        chk("mov_busy1", 16'(in_ready), 16'h0);
        tick();
        chk("mov_busy2", 16'(in_ready), 16'h0);
        tick();
        chk("mov_ready", 16'(in_ready), 16'h1);
        peek("mov_r1", 3'd1, 16'h1234);
        chk("model_r1", rm[1], 16'h1234);

        // 3: ADD with carry out, then ADC consumes it across parked cycles
        issue(2'd0, `OP_MOV, 3'd1, 3'd0, 1'b1, 16'hFFFF); idle(2);
        issue(2'd0, `OP_MOV, 3'd2, 3'd0, 1'b1, 16'h0001); idle(2);
        issue(2'd0, `OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0000); idle(2);
        peek("add_r1", 3'd1, 16'h0000);
        chk("add_carry", 16'(flags_out[3]), 16'h1);
        chk("model_add_flags", 16'(fm), 16'h001A);
        idle(3);
        issue(2'd0, `OP_ADC, 3'd3, 3'd0, 1'b1, 16'h0000); idle(2);
        peek("adc_r3", 3'd3, 16'h0001);

        // 4: CMP updates flags only
        issue(2'd0, `OP_MOV, 3'd1, 3'd0, 1'b1, 16'h0005); idle(2);
        issue(2'd0, `OP_CMP, 3'd1, 3'd0, 1'b1, 16'h0005); idle(2);
        peek("cmp_r1", 3'd1, 16'h0005);
        chk("cmp_zero", 16'(flags_out[1]), 16'h1);

        // 5: branches on C = 1
        issue(2'd0, `OP_MOV, 3'd5, 3'd0, 1'b1, 16'hFFFF); idle(2);
        issue(2'd0, `OP_ADD, 3'd5, 3'd0, 1'b1, 16'h0001); idle(2);
        chk("c_set", 16'(flags_out[3]), 16'h1);
        issue(2'd2, `OP_BRC, 3'd0, 3'd0, 1'b1, 16'h0040);
        chk("brc_br_cycle", 16'(pc_load), 16'h0);
        tick();
        chk("brc_load", 16'(pc_load), 16'h1);
        chk("brc_target", pc_target, 16'h0040);
        tick();
        chk("brc_drop", 16'(pc_load), 16'h0);
        issue(2'd2, `OP_BRNC, 3'd0, 3'd0, 1'b1, 16'h0040);
        tick();
        chk("brnc_not_taken", 16'(pc_load), 16'h0);
        issue(2'd2, `OP_RJMP, 3'd0, 3'd2, 1'b0, 16'hAAAA);
        tick();
        chk("rjmp_load", 16'(pc_load), 16'h1);
        chk("rjmp_target", pc_target, 16'h0001);
        idle(1);

        // 6: reset during EXEC abandons the instruction
        issue(2'd0, `OP_ADD, 3'd4, 3'd2, 1'b1, 16'h0100);
        rst_n = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        peek("rst_r4", 3'd4, 16'h0000);
        chk("rst_flags", 16'(flags_out), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);

        // Randomised traffic with occasional reset pulses
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                in_valid = 1'b1;
                tick();
                tick();
                rst_n = 1'b1;
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            in_kind   = 2'($urandom_range(0, 3));
            in_op     = 4'($urandom_range(0, 15));
            in_dst    = 3'($urandom_range(0, 7));
            in_src    = 3'($urandom_range(0, 7));
            in_imm_en = 1'($urandom_range(0, 1));
            in_imm    = pick_imm();
            dbg_addr  = 3'($urandom_range(0, 7));
            drv_accept = in_valid && (cyc >= free_at) && rst_n;
            tick();
        end
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue stage directly upstream of the 16-bit ALU. It accepts one decoded instruction at a time over a valid/ready handshake and holds the 8x16 general register file. It drives the ALU operand and operator inputs, writes the ALU result back, snapshots the ALU flags, and resolves branches from that snapshot into a PC-load request. Operator and branch encodings are the `OP_* macros in cpu_data.v.

Parameters:
REGS, 8, number of general registers; index width is log2(REGS) = 3.
WIDTH, 16, datapath width. Fixed to the ALU width; no other value is supported.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  decoded instruction present
in_ready  output  1  high only in IDLE; transfer occurs when in_valid and in_ready are both high at a rising edge
in_kind  input  2  0 = two-operand ALU op, 1 = single-operand ALU op, 2 = branch, 3 = NOP
in_op  input  4  `OP_* code (ALU operator or branch condition)
in_dst  input  3  destination register, also operand 1
in_src  input  3  source register, operand 2
in_imm_en  input  1  kind 0: use in_imm as operand 2; kind 2: target = in_imm instead of R[src]
in_imm  input  16  immediate value
alu_value1  output  16  registered, to ALU value1
alu_value2  output  16  registered, to ALU value2
alu_operator  output  4  registered, to ALU operator
alu_single  output  1  registered, to ALU single
alu_bus_out  input  16  ALU result
alu_flags  input  5  ALU flags {old_sign, C, V, Z, N}
flags_out  output  5  latched flag snapshot, same bit order as alu_flags
pc_load  output  1  one-cycle pulse when a branch is taken
pc_target  output  16  branch target; valid while pc_load is high
dbg_addr  input  3  debug register-file read address
dbg_data  output  16  combinational R[dbg_addr]

Behaviour:
- States: IDLE, EXEC, WB, BR. The block stays in IDLE while rst_n is low; a transfer offered during reset is not accepted.
- Reset values:
  - state = IDLE, all R[i] = 0, flags_out = 0
  - pc_load = 0, pc_target = 0
  - alu_value1 = alu_value2 = 0, alu_operator = `OP_MOV, alu_single = 0
- Park pattern: outside EXEC, the ALU inputs are `OP_MOV, single = 0, both values 0.
  - MOV leaves the ALU carry untouched, so ADC, SBC, RLC and RRC see the carry of the last real instruction.
  - ALU results computed while parked are ignored.
- IDLE accept by kind:
  - kind 0: value1 = R[dst], value2 = in_imm_en ? in_imm : R[src], single = 0, operator = in_op. Next state EXEC.
  - kind 1: value1 = R[dst], value2 = 0, single = 1, operator = in_op. Next state EXEC.
  - kind 2: latch the condition and the target (in_imm_en ? in_imm : R[src]). Next state BR.
  - kind 3: consumed with no effect; stays in IDLE.
- Operand read happens at the accept edge. Same-register reads (dst == src) are legal.
- EXEC: the ALU inputs are stable for the whole cycle, and the ALU registers its result at the closing edge. Next state WB.
- WB: alu_bus_out and alu_flags hold this instruction's result. At the closing edge:
  - write R[dst] = alu_bus_out, except kind 0 with op == `OP_CMP (flags only)
  - set flags_out = alu_flags
  - restore the park pattern; next state IDLE
- Latency: accept at edge E0, ALU computes at E1, result is visible on dbg_data after E2. Throughput is 1 instruction per 3 cycles; in_ready is low in EXEC and WB.
- BR, one cycle, with f = flags_out:
  - pc_load = 1 if the condition holds; pc_target = latched target.
  - Conditions:
    - BREQ: Z; BRNE: !Z
    - BRLT: N^V; BRGE: !(N^V)
    - BRC/BRLO: C; BRNC/BRSH: !C
    - BRO: V; BRNO: !V
    - BRN: N; BRNN: !N
    - RJMP: always
    - any other op: never taken
  - pc_load and pc_target are registered and drop to 0 on the next edge. Branches never touch R or flags_out. Next state IDLE.
- Reset asserted mid-instruction: the instruction is abandoned with no write-back, no pc_load and no flags update. All state returns to reset values immediately.

Test Plan:
1. Hold rst_n low, then release -> in_ready = 1, dbg_data = 0 for all addresses, flags_out = 0, alu_operator = `OP_MOV, pc_load = 0.
2. kind 0 `OP_MOV, dst 1, imm_en, imm 0x1234 -> in_ready low for exactly 2 cycles; alu_value2 = 0x1234 during EXEC; R1 = 0x1234 after E2.
3. R1 = 0xFFFF, R2 = 0x0001; ADD dst 1, src 2 -> R1 = 0x0000, flags_out[3] (C) = 1. Then ADC dst 3 (R3 = 0), imm 0 -> R3 = 0x0001.
4. R1 = 0x0005; CMP dst 1, imm 0x0005 -> R1 stays 0x0005; flags_out updated from ALU; no write strobe to R1.
5. With C = 1: BRC, imm_en, imm 0x0040 -> pc_load high for 1 cycle with pc_target = 0x0040. BRNC with the same flags -> pc_load stays 0. RJMP src 2 -> pc_target = R2.
6. rst_n pulsed low during EXEC of ADD dst 4 -> R4 stays 0, flags_out = 0, state IDLE, in_ready = 1 after release.
